// File: rtl/color_convert_pipe.sv
// BT.601 full-range RGB <-> YCbCr converter. It is a four-stage pipeline with
// per-beat mode selection, one global stall enable and a saturating count of clamp events.
module color_convert_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*DATA_WIDTH-1:0] in_data,
    input  logic                    in_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    output logic [3*DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    input  logic                    sat_clr,
    output logic [CNT_WIDTH-1:0]    sat_cnt
);

    localparam int AW    = DATA_WIDTH + 2;
    localparam int PW    = AW + 12;
    localparam int SW    = PW + 2;
    localparam int HALF  = 1 << (DATA_WIDTH - 1);
    localparam int MAXV  = (1 << DATA_WIDTH) - 1;
    localparam int ROUND = 512;

    // Rows give the output components and columns give the input components (c0,c1,c2).
    localparam logic signed [11:0] FWD_COEF [3][3] = '{
        '{ 12'sd306,  12'sd601,  12'sd117},
        '{-12'sd173, -12'sd339,  12'sd512},
        '{ 12'sd512, -12'sd429, -12'sd83 }};
    localparam logic signed [11:0] INV_COEF [3][3] = '{
        '{12'sd1024,  12'sd0,    12'sd1436},
        '{12'sd1024, -12'sd352, -12'sd731 },
        '{12'sd1024,  12'sd1815, 12'sd0   }};

    logic                 en;
    logic signed [AW-1:0] a_next [3];
    logic signed [AW-1:0] s1_a [3];
    logic                 s1_valid, s1_mode, s1_last;
    logic signed [PW-1:0] p_next [3][3];
    logic signed [PW-1:0] s2_p [3][3];
    logic                 s2_valid, s2_mode, s2_last;
    logic signed [SW-1:0] s3_sum [3];
    logic                 s3_valid, s3_mode, s3_last;
    logic signed [SW-1:0] shifted [3];
    logic [3*DATA_WIDTH-1:0] res_data;
    logic [2:0]           clip;
    logic [1:0]           clip_cnt;
    logic [1:0]           out_ncl;
    logic [CNT_WIDTH:0]   sat_sum;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Chroma is re-centred around zero only in inverse mode; luma and RGB stay unsigned.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            a_next[k] = $signed({2'b00, in_data[k*DATA_WIDTH +: DATA_WIDTH]});
            if (in_mode && k != 0)
                a_next[k] = a_next[k] - AW'(HALF);
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p_next[r][c] = PW'(s1_a[c]) *
                               PW'(s1_mode ? INV_COEF[r][c] : FWD_COEF[r][c]);
    end

    // Rounding uses an arithmetic shift, so negative sums floor before the clamp sees them.
    always_comb begin
        res_data = '0;
        clip     = '0;
        for (int r = 0; r < 3; r++) begin
            shifted[r] = (s3_sum[r] + SW'(ROUND)) >>> 10;
            if (!s3_mode && r != 0)
                shifted[r] = shifted[r] + SW'(HALF);
            if (shifted[r][SW-1]) begin
                res_data[r*DATA_WIDTH +: DATA_WIDTH] = '0;
                clip[r] = 1'b1;
            end else if (shifted[r] > SW'(MAXV)) begin
                res_data[r*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b1}};
                clip[r] = 1'b1;
            end else begin
                res_data[r*DATA_WIDTH +: DATA_WIDTH] = shifted[r][DATA_WIDTH-1:0];
            end
        end
        clip_cnt = 2'(clip[0]) + 2'(clip[1]) + 2'(clip[2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_last  <= 1'b0;
            s3_valid <= 1'b0;
            s3_mode  <= 1'b0;
            s3_last  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_ncl   <= '0;
            for (int k = 0; k < 3; k++) begin
                s1_a[k]   <= '0;
                s3_sum[k] <= '0;
                for (int c = 0; c < 3; c++)
                    s2_p[k][c] <= '0;
            end
        end else if (en) begin
            s1_valid <= in_valid;
            s1_mode  <= in_mode;
            s1_last  <= in_last;
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_last  <= s1_last;
            s3_valid <= s2_valid;
            s3_mode  <= s2_mode;
            s3_last  <= s2_last;
            out_valid <= s3_valid;
            out_last  <= s3_last;
            out_data  <= res_data;
            out_ncl   <= clip_cnt;
            for (int k = 0; k < 3; k++) begin
                s1_a[k]   <= a_next[k];
                s3_sum[k] <= SW'(s2_p[k][0]) + SW'(s2_p[k][1]) + SW'(s2_p[k][2]);
                for (int c = 0; c < 3; c++)
                    s2_p[k][c] <= p_next[k][c];
            end
        end
    end

    assign sat_sum = {1'b0, sat_cnt} + (CNT_WIDTH+1)'(out_ncl);

    // A clear wins over a same-cycle increment, and the counter pins at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt <= '0;
        else if (sat_clr)
            sat_cnt <= '0;
        else if (out_valid && out_ready)
            sat_cnt <= sat_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sat_sum[CNT_WIDTH-1:0];
    end

endmodule

// File: doc/color_convert_pipe.md
COLOR_CONVERT_PIPE -- requirements
Module: color_convert_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: unsigned bits per colour component.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the saturation event counter.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_data, input, 3*DATA_WIDTH, {c2,c1,c0}: forward mode {B,G,R}, inverse mode {Cr,Cb,Y}.
REQ-006 SHALL have port in_mode, input, 1: 0 = RGB->YCbCr (forward), 1 = YCbCr->RGB (inverse); sampled per beat.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_last (input, 1), where in_last is a sideband carried with each beat.
REQ-008 SHALL have port out_data, output, 3*DATA_WIDTH: forward {Cr,Cb,Y}, inverse {B,G,R}.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_last (output, 1).
REQ-010 SHALL have port sat_clr, input, 1: synchronous clear of sat_cnt.
REQ-011 SHALL have port sat_cnt, output, CNT_WIDTH: count of output components that were clamped.

Function
REQ-012 Arithmetic:
- Coefficients are fixed signed 12-bit, 10 fractional bits (BT.601 full range).
- Forward: Y {306,601,117}, Cb {-173,-339,512}, Cr {512,-429,-83}, applied to (R,G,B).
- Inverse: R = 1024Y + 1436Cr'; G = 1024Y - 352Cb' - 731Cr'; B = 1024Y + 1815Cb'.
REQ-013 Inverse mode SHALL form Cb' = Cb - 2^(DATA_WIDTH-1) and Cr' = Cr - 2^(DATA_WIDTH-1) as signed values before multiplying.
REQ-014 Each output SHALL be computed as: signed full-precision sum of products + 512, arithmetic shift right by 10; forward mode then adds 2^(DATA_WIDTH-1) to Cb and Cr.
REQ-015 Each result SHALL be clamped to [0, 2^DATA_WIDTH-1]; intermediate widths SHALL be wide enough that no overflow occurs before the clamp.
REQ-016 Pipeline SHALL be 4 register stages: S1 input/offset, S2 products, S3 sums, S4 round/clamp/output.
- Latency: 4 cycles from input handshake to out_valid, absent stalls.
REQ-017 in_mode and in_last SHALL travel with their beat through every stage; a mode change between consecutive beats SHALL take effect on the next beat with no bubble or flush.
REQ-018 Advance enable SHALL be en = !out_valid || out_ready; all stages advance together only when en=1.
- in_ready = en.
- A beat is accepted when in_valid && in_ready.
- A stage's valid loads 0 when it receives no beat.
REQ-019 While out_valid && !out_ready, out_data, out_last and out_valid SHALL hold stable.
REQ-020 sat_cnt SHALL increase by the number (0-3) of clamped components of each beat when it completes an output handshake.
- It saturates at 2^CNT_WIDTH-1 and never wraps.
REQ-021 sat_clr SHALL take priority over a same-cycle increment; sat_cnt SHALL read 0 on the following cycle.
REQ-022 The block SHALL have no combinational path from in_* to out_*; the only combinational input-to-output path is out_ready -> in_ready.

Reset
REQ-023 While rst is high, all stage valid flags, out_valid, out_last and sat_cnt SHALL be 0, and out_data SHALL be 0.
REQ-024 in_ready SHALL be 1 during reset (consequence of out_valid=0); beats presented while rst is high are discarded.
REQ-025 Asserting rst mid-stream SHALL drop all in-flight beats; after rst is released, the first accepted beat appears 4 cycles later.

Verification
REQ-026 Forward, in_data {B,G,R} = {255,255,255}, out_ready=1 -> 4 cycles later out_data {Cr,Cb,Y} = {128,128,255}, sat_cnt unchanged.
REQ-027 Inverse, {Cr,Cb,Y} = {128,128,128} -> {B,G,R} = {128,128,128}; then {Cr,Cb,Y} = {0,128,0} -> {B,G,R} = {0,91,0}, sat_cnt += 1 (R clamped).
REQ-028 Inverse, {Cr,Cb,Y} = {255,128,255} -> R clamped to 255, G = 164, B = 255, sat_cnt += 1.
REQ-029 Alternate in_mode every beat, 8 beats back-to-back, out_ready=1 -> 8 consecutive out_valid cycles, each correct for its own mode, and out_last aligned to its beat.
REQ-030 Hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready drops once the output is valid; out_data stays stable; no beat lost or duplicated after out_ready returns to 1.
REQ-031 sat_cnt preset near maximum via saturating stimulus -> sticks at 2^CNT_WIDTH-1; sat_clr with a same-cycle clamp reads 0; rst mid-stream -> out_valid=0 and the pipeline is empty.
